// File: rtl/dds_cmd_parser_if.sv
// Byte-in / register-write-out bundle for the DDS command parser.
// The master side drives received UART bytes; the slave side (the parser)
// drives register writes and status back.
interface dds_cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        vld;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        output rx_data, rx_vld,
        input  vld, addr, data_in, busy, err, err_code
    );

    modport slave (
        input  rx_data, rx_vld,
        output vld, addr, data_in, busy, err, err_code
    );
endinterface

// File: rtl/dds_cmd_parser.sv
// Byte-stream command parser feeding the DDS register bank.
// Frame: HEADER, ADDR, D3, D2, D1, D0, CHK  (CHK = 8-bit wrapping sum of ADDR..D0).
// Good frames become one-cycle register writes. Bad checksum, illegal address
// or an inter-byte stall drops the frame and raises a one-cycle err strobe.
module dds_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 500_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    dds_cmd_parser_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_CHK  = 2'd3;

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_ADDR    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    logic [1:0]    state_reg,    state_next;
    logic [1:0]    cnt_reg,      cnt_next;
    logic [7:0]    addr_b_reg,   addr_b_next;
    logic [31:0]   shift_reg,    shift_next;
    logic [7:0]    sum_reg,      sum_next;
    logic [TW-1:0] timer_reg,    timer_next;
    logic          vld_reg,      vld_next;
    logic          err_reg,      err_next;
    logic [1:0]    err_code_reg, err_code_next;
    logic [31:0]   addr_reg,     addr_next;
    logic [31:0]   data_reg,     data_next;

    logic addr_legal;

    // Only word-aligned addresses 0x00..0x0C map onto real DDS registers.
    assign addr_legal = (addr_b_reg[7:4] == 4'h0) && (addr_b_reg[1:0] == 2'b00);

    // Next-state logic: a received byte always takes priority over the timeout.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_b_next   = addr_b_reg;
        shift_next    = shift_reg;
        sum_next      = sum_reg;
        timer_next    = timer_reg;
        vld_next      = 1'b0;
        err_next      = 1'b0;
        err_code_next = err_code_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;

        if (bus.rx_vld) begin
            timer_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.rx_data == HEADER) begin
                        state_next = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_b_next = bus.rx_data;
                    sum_next    = bus.rx_data;
                    cnt_next    = 2'd0;
                    state_next  = ST_DATA;
                end
                ST_DATA: begin
                    shift_next = {shift_reg[23:0], bus.rx_data};
                    sum_next   = sum_reg + bus.rx_data;
                    if (cnt_reg == 2'd3) begin
                        state_next = ST_CHK;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    if (bus.rx_data != sum_reg) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_CHK;
                    end else if (!addr_legal) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_ADDR;
                    end else begin
                        vld_next  = 1'b1;
                        addr_next = {24'h0, addr_b_reg};
                        data_next = shift_reg;
                    end
                end
            endcase
        end else if (state_reg != ST_IDLE) begin
            if (timer_reg == TIMER_LAST) begin
                state_next    = ST_IDLE;
                timer_next    = '0;
                err_next      = 1'b1;
                err_code_next = ERR_TIMEOUT;
            end else begin
                timer_next = timer_reg + 1'b1;
            end
        end else begin
            timer_next = '0;
        end
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 2'd0;
            addr_b_reg   <= 8'h0;
            shift_reg    <= 32'h0;
            sum_reg      <= 8'h0;
            timer_reg    <= '0;
            vld_reg      <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'd0;
            addr_reg     <= 32'h0;
            data_reg     <= 32'h0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_b_reg   <= addr_b_next;
            shift_reg    <= shift_next;
            sum_reg      <= sum_next;
            timer_reg    <= timer_next;
            vld_reg      <= vld_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
        end
    end

    assign bus.vld      = vld_reg;
    assign bus.err      = err_reg;
    assign bus.err_code = err_code_reg;
    assign bus.addr     = addr_reg;
    assign bus.data_in  = data_reg;
    assign bus.busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed bench for dds_cmd_parser: good frames, checksum / address errors,
// inter-byte timeout, stray bytes, back-to-back frames and mid-frame reset.
module tb_dds_cmd_parser;

    localparam int TO = 16;

    typedef logic [7:0] byte_q_t [$];

    logic clk;
    logic rst_n;

    dds_cmd_parser_if bus ();

    dds_cmd_parser #(
        .HEADER      (8'hA5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int vld_count  = 0;
    int err_count  = 0;
    int both_count = 0;

    // Count strobes away from the active edge.
    always @(negedge clk) begin
        if (bus.vld) vld_count++;
        if (bus.err) err_count++;
        if (bus.vld && bus.err) both_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=0x%08h exp=0x%08h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Bytes on consecutive cycles, strobe dropped after the last one.
    task automatic send_frame(input byte_q_t q);
        foreach (q[i]) begin
            @(negedge clk);
            bus.rx_data = q[i];
            bus.rx_vld  = 1'b1;
        end
        @(negedge clk);
        bus.rx_vld  = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    int v0, e0;
    byte_q_t frame;

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_vld",   {31'h0, bus.vld},      32'h0);
        check_val("rst_err",   {31'h0, bus.err},      32'h0);
        check_val("rst_code",  {30'h0, bus.err_code}, 32'h0);
        check_val("rst_addr",  bus.addr,              32'h0);
        check_val("rst_data",  bus.data_in,           32'h0);
        check_val("rst_busy",  {31'h0, bus.busy},     32'h0);

        // Good frame
        v0 = vld_count; e0 = err_count;
        frame = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'hA7, 8'hC5, 8'h70};
        send_frame(frame);
        repeat (3) @(negedge clk);
        check_val("good_vld",  vld_count - v0, 32'd1);
        check_val("good_err",  err_count - e0, 32'd0);
        check_val("good_addr", bus.addr,       32'h04);
        check_val("good_data", bus.data_in,    32'h0000A7C5);
        check_val("good_busy", {31'h0, bus.busy}, 32'h0);

        // Checksum error
        v0 = vld_count; e0 = err_count;
        frame = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'hA7, 8'hC5, 8'h71};
        send_frame(frame);
        repeat (3) @(negedge clk);
        check_val("chk_err",   err_count - e0, 32'd1);
        check_val("chk_code",  {30'h0, bus.err_code}, 32'd1);
        check_val("chk_vld",   vld_count - v0, 32'd0);
        check_val("chk_addr",  bus.addr,       32'h04);
        check_val("chk_data",  bus.data_in,    32'h0000A7C5);

        // Illegal address
        v0 = vld_count; e0 = err_count;
        frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11};
        send_frame(frame);
        repeat (3) @(negedge clk);
        check_val("adr_err",   err_count - e0, 32'd1);
        check_val("adr_code",  {30'h0, bus.err_code}, 32'd2);
        check_val("adr_vld",   vld_count - v0, 32'd0);

        // Timeout: ADDR byte sampled, then silence
        v0 = vld_count; e0 = err_count;
        frame = '{8'hA5, 8'h00};
        send_frame(frame);
        check_val("to_busy_mid", {31'h0, bus.busy}, 32'h1);
        repeat (TO - 2) @(negedge clk);
        check_val("to_early",  err_count - e0, 32'd0);
        check_val("to_busy_pre", {31'h0, bus.busy}, 32'h1);
        repeat (5) @(negedge clk);
        check_val("to_err",    err_count - e0, 32'd1);
        check_val("to_code",   {30'h0, bus.err_code}, 32'd3);
        check_val("to_busy",   {31'h0, bus.busy}, 32'h0);
        check_val("to_vld",    vld_count - v0, 32'd0);

        v0 = vld_count;
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
        send_frame(frame);
        repeat (3) @(negedge clk);
        check_val("post_vld",  vld_count - v0, 32'd1);
        check_val("post_addr", bus.addr,       32'h0);
        check_val("post_data", bus.data_in,    32'h00000100);

        // Stray bytes ahead of a frame
        v0 = vld_count; e0 = err_count;
        frame = '{8'h12, 8'h34, 8'hA5, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h16};
        send_frame(frame);
        repeat (3) @(negedge clk);
        check_val("stray_vld", vld_count - v0, 32'd1);
        check_val("stray_err", err_count - e0, 32'd0);
        check_val("stray_addr", bus.addr,      32'h0C);
        check_val("stray_data", bus.data_in,   32'h0000000A);

        // Asynchronous reset mid-frame
        frame = '{8'hA5, 8'h04, 8'h00};
        send_frame(frame);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_busy", {31'h0, bus.busy}, 32'h0);
        check_val("mrst_addr", bus.addr,       32'h0);
        check_val("mrst_data", bus.data_in,    32'h0);
        check_val("mrst_code", {30'h0, bus.err_code}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back frames after reset
        v0 = vld_count; e0 = err_count;
        frame = '{8'hA5, 8'h08, 8'h12, 8'h34, 8'h56, 8'h78, 8'h1C};
        send_frame(frame);
        repeat (1) @(negedge clk);
        check_val("b1_addr",   bus.addr,       32'h08);
        check_val("b1_data",   bus.data_in,    32'h12345678);
        frame = '{8'hA5, 8'h08, 8'h12, 8'h34, 8'h56, 8'h78, 8'h1C,
                  8'hA5, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h16};
        send_frame(frame);
        repeat (3) @(negedge clk);
        check_val("b2b_vld",   vld_count - v0, 32'd3);
        check_val("b2b_err",   err_count - e0, 32'd0);
        check_val("b2b_addr",  bus.addr,       32'h0C);
        check_val("b2b_data",  bus.data_in,    32'h0000000A);

        check_val("vld_err_excl", both_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
